// File: rtl/mem_ctrl.sv
// Purpose : single-port memory controller; single-word writes and 1..16-word read bursts.
// Latency : write commits 1 edge after accept (wdone next cycle); first read word 2 cycles after accept.
// Backpr. : no queuing; req is only honoured while ready=1, otherwise dropped.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req, we, addr, wdata, len  CPU request (we=1 write, we=0 burst read of len+1 words)
//   ready                      high while idle and able to accept a request
//   rvalid, rdata              read word strobe and data (rdata straight from memory port)
//   wdone                      one-cycle pulse after a write has been committed
//   mem_address, mem_data_in,
//   mem_write, mem_data_out    synchronous memory interface (one-edge read latency)
module mem_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [3:0]               len,
    output logic                     ready,
    output logic                     rvalid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     wdone,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    output logic                     mem_write,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    state_t     state;
    logic [3:0] cnt;

    assign ready = (state == IDLE);

    // The memory registers its read port, so the word addressed on a READ
    // edge appears on mem_data_out exactly when rvalid (set on that edge) is high.
    assign rdata = mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rvalid      <= 1'b0;
            wdone       <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            // Strobes default low; each state re-asserts what it needs.
            rvalid    <= 1'b0;
            wdone     <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_address <= addr;
                        if (we) begin
                            mem_data_in <= wdata;
                            mem_write   <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            cnt   <= len;
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    // Memory commits on this edge; mem_write drops via the default.
                    wdone <= 1'b1;
                    state <= IDLE;
                end
                READ: begin
                    // This edge issues the current address to the memory.
                    rvalid <= 1'b1;
                    if (cnt != 4'd0) begin
                        mem_address <= mem_address + ADDR_ONE;
                        cnt         <= cnt - 4'd1;
                    end else begin
                        // Back to IDLE: ready rises in the same cycle as the last rvalid.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, we;
    logic [7:0] addr, wdata;
    logic [3:0] len;
    logic       ready, rvalid, wdone, mem_write;
    logic [7:0] rdata, mem_address, mem_data_in, mem_data_out;

    int checks   = 0;
    int failures = 0;

    // Memory attached to the controller, with a bench-only preload port.
    logic [7:0] mem [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'd0, bd_dat = 8'd0;

    // Reference contents: what every address must hold according to the
    // writes the bench has asked for.
    logic [7:0] ref_mem [256];

    mem_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .len(len), .ready(ready), .rvalid(rvalid), .rdata(rdata), .wdone(wdone),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_dat;
        else if (mem_write) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_dat = d; ref_mem[a] = d;
        tick;
        bd_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'd0; wdata = 8'd0; len = 4'd0;
        #2;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (wdone !== 1'b0) begin failures++; $display("FAIL reset_wdone got=%b exp=0", wdone); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        checks++; if (mem_address !== 8'h00) begin failures++; $display("FAIL reset_mem_address got=%h exp=00", mem_address); end
        checks++; if (mem_data_in !== 8'h00) begin failures++; $display("FAIL reset_mem_data_in got=%h exp=00", mem_data_in); end
        // Fill the whole memory with random contents while still in reset.
        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
        checks++; if (ready !== 1'b1 || rvalid !== 1'b0 || mem_write !== 1'b0)
            begin failures++; $display("FAIL reset_held ready=%b rvalid=%b mem_write=%b exp=1/0/0", ready, rvalid, mem_write); end
        #2 rst_n = 1'b1;
        tick;
    endtask

    // Write 0x5A to 0x10 right after reset release, then read it back (len=0).
    task automatic test_write_then_read;
        req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'h5A; len = 4'($urandom);
        tick;
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL wr_mem_write got=%b exp=1", mem_write); end
        checks++; if (mem_address !== 8'h10) begin failures++; $display("FAIL wr_mem_address got=%h exp=10", mem_address); end
        checks++; if (mem_data_in !== 8'h5A) begin failures++; $display("FAIL wr_mem_data_in got=%h exp=5a", mem_data_in); end
        checks++; if (ready !== 1'b0 || wdone !== 1'b0) begin failures++; $display("FAIL wr_busy ready=%b wdone=%b exp=0/0", ready, wdone); end
        req = 1'b0; we = 1'($urandom); addr = 8'($urandom);
        tick;
        ref_mem[8'h10] = 8'h5A;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL wr_mem_write_drop got=%b exp=0", mem_write); end
        checks++; if (wdone !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL wr_done wdone=%b ready=%b exp=1/1", wdone, ready); end
        req = 1'b1; we = 1'b0; addr = 8'h10; len = 4'd0;
        tick;
        checks++; if (wdone !== 1'b0 || rvalid !== 1'b0 || ready !== 1'b0)
            begin failures++; $display("FAIL rd0_accept wdone=%b rvalid=%b ready=%b exp=0/0/0", wdone, rvalid, ready); end
        req = 1'b0;
        tick;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h5A) begin failures++; $display("FAIL rd0_data rvalid=%b rdata=%h exp=1/5a", rvalid, rdata); end
        tick;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd0_end rvalid=%b exp=0", rvalid); end
    endtask

    task automatic test_random_writes;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, d;
            a = 8'h40 + 8'($urandom_range(0, 15));
            d = 8'($urandom);
            req = 1'b1; we = 1'b1; addr = a; wdata = d;
            tick;
            checks++; if (mem_write !== 1'b1 || mem_address !== a || mem_data_in !== d)
                begin failures++; $display("FAIL rw_issue we=%b adr=%h dat=%h exp=1/%h/%h", mem_write, mem_address, mem_data_in, a, d); end
            // req held high in the WRITE cycle must be ignored.
            we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
            tick;
            ref_mem[a] = d;
            checks++; if (wdone !== 1'b1 || mem_write !== 1'b0)
                begin failures++; $display("FAIL rw_done wdone=%b mem_write=%b exp=1/0", wdone, mem_write); end
            req = 1'b0;
            tick;
            checks++; if (wdone !== 1'b0 || mem_write !== 1'b0)
                begin failures++; $display("FAIL rw_quiet wdone=%b mem_write=%b exp=0/0", wdone, mem_write); end
        end
    endtask

    // Fixed bursts (plain and wrapping) followed by random ones; req is
    // toggled randomly while busy and must have no effect.
    task automatic test_read_bursts;
        for (int i = 0; i < 4; i++) bd_write(8'h20 + 8'(i), 8'(i + 1));
        bd_write(8'hFE, 8'hA1); bd_write(8'hFF, 8'hB2); bd_write(8'h00, 8'hC3);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a;
            logic [3:0] l;
            int         n;
            if (i == 0)      begin a = 8'h20; l = 4'd3; end
            else if (i == 1) begin a = 8'hFE; l = 4'd2; end
            else begin a = 8'h38 + 8'($urandom_range(0, 15)); l = 4'($urandom_range(0, 15)); end
            n = int'(l) + 1;
            req = 1'b1; we = 1'b0; addr = a; len = l;
            tick;
            req = 1'b0;
            for (int k = 0; k <= n + 1; k++) begin
                logic       exp_v, exp_r;
                logic [7:0] ed, ea;
                exp_v = (k >= 1 && k <= n);
                exp_r = (k >= n);
                ed = ref_mem[a + 8'(k - 1)];
                ea = a + 8'(k);
                checks++; if (rvalid !== exp_v) begin failures++; $display("FAIL burst%0d_rvalid k=%0d got=%b exp=%b", i, k, rvalid, exp_v); end
                checks++; if (ready !== exp_r) begin failures++; $display("FAIL burst%0d_ready k=%0d got=%b exp=%b", i, k, ready, exp_r); end
                checks++; if (mem_write !== 1'b0 || wdone !== 1'b0)
                    begin failures++; $display("FAIL burst%0d_nowrite k=%0d mem_write=%b wdone=%b exp=0/0", i, k, mem_write, wdone); end
                if (exp_v) begin
                    checks++; if (rdata !== ed) begin failures++; $display("FAIL burst%0d_rdata k=%0d got=%h exp=%h", i, k, rdata, ed); end
                end
                if (k < n) begin
                    checks++; if (mem_address !== ea) begin failures++; $display("FAIL burst%0d_addr k=%0d got=%h exp=%h", i, k, mem_address, ea); end
                end
                if (k < n) begin
                    req = 1'($urandom); we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom); len = 4'($urandom);
                end else begin
                    req = 1'b0;
                end
                if (k <= n) tick;
            end
        end
    endtask

    // Write request held through a 16-word burst: taken only in the last rvalid cycle.
    task automatic test_back_to_back;
        logic [7:0] a, wd;
        a  = 8'($urandom);
        wd = ~ref_mem[a];
        req = 1'b1; we = 1'b0; addr = a; len = 4'd15;
        tick;
        we = 1'b1; wdata = wd;
        for (int k = 0; k <= 16; k++) begin
            logic exp_v;
            exp_v = (k >= 1);
            checks++; if (rvalid !== exp_v || ready !== (k == 16))
                begin failures++; $display("FAIL b2b_flags k=%0d rvalid=%b ready=%b exp=%b/%b", k, rvalid, ready, exp_v, (k == 16)); end
            checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL b2b_early_write k=%0d got=%b exp=0", k, mem_write); end
            if (exp_v) begin
                checks++; if (rdata !== ref_mem[a + 8'(k - 1)])
                    begin failures++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rdata, ref_mem[a + 8'(k - 1)]); end
            end
            tick;
        end
        checks++; if (mem_write !== 1'b1 || mem_address !== a || mem_data_in !== wd || rvalid !== 1'b0)
            begin failures++; $display("FAIL b2b_accept we=%b adr=%h dat=%h rvalid=%b exp=1/%h/%h/0", mem_write, mem_address, mem_data_in, rvalid, a, wd); end
        req = 1'b0;
        tick;
        ref_mem[a] = wd;
        checks++; if (wdone !== 1'b1) begin failures++; $display("FAIL b2b_wdone got=%b exp=1", wdone); end
        req = 1'b1; we = 1'b0; addr = a; len = 4'd0;
        tick;
        req = 1'b0;
        tick;
        checks++; if (rvalid !== 1'b1 || rdata !== wd) begin failures++; $display("FAIL b2b_readback rvalid=%b rdata=%h exp=1/%h", rvalid, rdata, wd); end
        tick;
    endtask

    task automatic test_reset_abort;
        logic [7:0] a, old;
        a = 8'($urandom);
        // Reset during the second rvalid cycle of a len=7 burst.
        req = 1'b1; we = 1'b0; addr = a; len = 4'd7;
        tick;
        req = 1'b0;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0 || ready !== 1'b1 || wdone !== 1'b0 || mem_write !== 1'b0)
            begin failures++; $display("FAIL rstb_flags rvalid=%b ready=%b wdone=%b mem_write=%b exp=0/1/0/0", rvalid, ready, wdone, mem_write); end
        checks++; if (mem_address !== 8'h00 || mem_data_in !== 8'h00)
            begin failures++; $display("FAIL rstb_regs adr=%h dat=%h exp=00/00", mem_address, mem_data_in); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rstb_norvalid k=%0d got=%b exp=0", k, rvalid); end
        end
        #3 rst_n = 1'b1;
        tick;
        checks++; if (rvalid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL rstb_after rvalid=%b ready=%b exp=0/1", rvalid, ready); end
        // Reset one cycle into a write: the memory must keep its old word.
        old = ref_mem[a];
        req = 1'b1; we = 1'b1; addr = a; wdata = ~old;
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rstw_mem_write got=%b exp=0", mem_write); end
        req = 1'b0;
        tick; tick;
        checks++; if (wdone !== 1'b0) begin failures++; $display("FAIL rstw_wdone got=%b exp=0", wdone); end
        #3 rst_n = 1'b1;
        tick;
        req = 1'b1; we = 1'b0; addr = a; len = 4'd2;
        tick;
        req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++; if (rvalid !== 1'b1 || rdata !== ref_mem[a + 8'(k - 1)])
                begin failures++; $display("FAIL rst_readback k=%0d rvalid=%b rdata=%h exp=1/%h", k, rvalid, rdata, ref_mem[a + 8'(k - 1)]); end
        end
        tick;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_readback_end rvalid=%b exp=0", rvalid); end
    endtask

    initial begin
        test_reset;
        test_write_then_read;
        test_random_writes;
        test_read_bursts;
        test_back_to_back;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: word address width, identical to the attached memory.
REQ-002 Parameter DATA_WIDTH, default 8: word width, identical to the attached memory.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  CPU request strobe; accepted only on an edge where ready=1.
REQ-006 we  input  1  request type: 1 = single write, 0 = burst read.
REQ-007 addr  input  ADDRESS_WIDTH  request start address.
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 len  input  4  read burst length minus one (0 = 1 word, 15 = 16 words); ignored for writes.
REQ-010 ready  output  1  high iff the controller is in IDLE.
REQ-011 rvalid  output  1  registered; rdata holds a valid read word this cycle.
REQ-012 rdata  output  DATA_WIDTH  read data, driven directly from mem_data_out.
REQ-013 wdone  output  1  registered one-cycle pulse; a write has been committed.
REQ-014 mem_address  output  ADDRESS_WIDTH  registered address to the memory.
REQ-015 mem_data_in  output  DATA_WIDTH  registered write data to the memory.
REQ-016 mem_write  output  1  registered write enable to the memory.
REQ-017 mem_data_out  input  DATA_WIDTH  memory read port, registered inside the memory with one-edge latency.

Function
REQ-018 The state machine SHALL have three states: IDLE, WRITE and READ.
REQ-019 IDLE, req=1 and we=1 at edge T0: latch mem_address<=addr, mem_data_in<=wdata, mem_write<=1, and go to WRITE.
REQ-020 WRITE at edge T1: the memory commits the word; mem_write<=0, wdone<=1 for exactly one cycle, and the state returns to IDLE (ready=1 after T1).
REQ-021 IDLE, req=1 and we=0 at edge T0: latch mem_address<=addr, burst counter cnt<=len, mem_write stays 0, and go to READ.
REQ-022 Every edge in READ samples the current mem_address into the memory and sets an issue flag, so rvalid=1 in the following cycle.
REQ-023 On that same READ edge: if cnt!=0, then mem_address<=mem_address+1 and cnt<=cnt-1; if cnt==0, the state returns to IDLE.
REQ-024 Address increment wraps modulo 2^ADDRESS_WIDTH (e.g. 0xFF+1 = 0x00 at width 8).
REQ-025 Read latency: with the request accepted at T0, the first rvalid cycle follows T1 (2 cycles); rvalid is high for exactly len+1 consecutive cycles, carrying words addr, addr+1, ... in order.
REQ-026 rvalid SHALL be 0 in every cycle not covered by REQ-025; wdone SHALL be 0 except for the pulse in REQ-020.
REQ-027 The controller SHALL accept a new request in the same cycle as the last rvalid of a burst; the two transactions must not corrupt each other.
REQ-028 req while ready=0 SHALL be ignored (no queuing), and inputs are don't-care outside the accept edge.
REQ-029 mem_write SHALL never be high outside WRITE, and never for more than one cycle per accepted write.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force state IDLE, ready=1, rvalid=0, wdone=0, mem_write=0, mem_address=0, mem_data_in=0, cnt=0.
REQ-031 Reset mid-burst or mid-write SHALL abort the transaction: no further rvalid or wdone, and no memory write after rst_n falls.
REQ-032 The first request SHALL be accepted on the first rising edge with rst_n=1 and ready=1.

Verification
REQ-033 Write 0x5A to 0x10, then read len=0 at 0x10 -> mem_write high for one cycle, wdone pulse one cycle after; rvalid for one cycle, 2 cycles after accept, rdata=0x5A.
REQ-034 Preload 0x20..0x23 = 1,2,3,4; read addr=0x20, len=3 -> rvalid for exactly 4 consecutive cycles, rdata 1,2,3,4; ready=0 during the burst.
REQ-035 Read addr=0xFE, len=2 -> words from 0xFE, 0xFF, 0x00; mem_address wraps.
REQ-036 Hold req=1 with we=1 throughout a len=15 burst -> no write occurs before the burst ends; the write is accepted in the cycle of the last rvalid and commits correctly.
REQ-037 Assert rst_n=0 asynchronously during cycle 2 of a len=7 burst -> rvalid=0 immediately, all outputs at reset values, no later rvalid; a read after release returns correct data.
